// File: rtl/sc_chain_loader.sv
// Writer end of the configuration scan chain: serialises host words onto the chain
// head, drives the chain shift enable and returns the bits falling out of the tail.
module sc_chain_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int CHAIN_LEN  = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  sc_head,
   output logic                  sc_shift_en,
   input  logic                  sc_tail,
   output logic [DATA_WIDTH-1:0] rb_data,
   output logic                  rb_valid,
   output logic                  rb_last,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            dbg_state
);
   // Handshake: a word transfers on a clk edge where in_valid and in_ready are both 1;
   // in_ready is only high in LOAD, and in_valid is not looked at in any other state.
   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int WB_W  = $clog2(DATA_WIDTH + 1);
   localparam int IDX_W = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

   state_t                state, state_n;
   logic [DATA_WIDTH-1:0] shift_reg, shift_n;
   logic [CNT_W-1:0]      bits_sent, bits_n, remaining;
   logic [WB_W-1:0]       word_bits, wbits_n;
   logic [DATA_WIDTH-1:0] rb_reg, rb_reg_n, captured, rb_data_n;
   logic [IDX_W-1:0]      rb_idx, rb_idx_n;
   logic                  rb_valid_n, rb_last_n, final_shift;

   assign dbg_state = state;

   always_comb begin
      state_n    = state;
      shift_n    = shift_reg;
      bits_n     = bits_sent;
      wbits_n    = word_bits;
      rb_reg_n   = rb_reg;
      rb_idx_n   = rb_idx;
      rb_data_n  = rb_data;
      rb_valid_n = 1'b0;
      rb_last_n  = 1'b0;
      remaining  = CNT_W'(CHAIN_LEN) - bits_sent;
      final_shift = (bits_sent == CNT_W'(CHAIN_LEN - 1));
      captured   = rb_reg;
      captured[rb_idx] = sc_tail;
      case (state)
         IDLE: begin
            if (start) begin
               state_n  = LOAD;
               bits_n   = '0;
               rb_idx_n = '0;
               rb_reg_n = '0;
            end
         end
         LOAD: begin
            if (in_valid) begin
               shift_n = in_data;
               // The last word of a load may be only partly shifted.
               wbits_n = (32'(remaining) >= DATA_WIDTH) ? WB_W'(DATA_WIDTH) : WB_W'(remaining);
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            shift_n = shift_reg >> 1;
            bits_n  = bits_sent + CNT_W'(1);
            wbits_n = word_bits - WB_W'(1);
            if (rb_idx == IDX_W'(DATA_WIDTH - 1) || final_shift) begin
               rb_data_n  = captured;
               rb_valid_n = 1'b1;
               rb_last_n  = final_shift;
               rb_reg_n   = '0;
               rb_idx_n   = '0;
            end else begin
               rb_reg_n = captured;
               rb_idx_n = rb_idx + IDX_W'(1);
            end
            if (word_bits == WB_W'(1)) state_n = final_shift ? DONE : LOAD;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so sc_head and
   // sc_shift_en come straight from flops and stay glitch-free for the clock gate.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         shift_reg   <= '0;
         bits_sent   <= '0;
         word_bits   <= '0;
         rb_reg      <= '0;
         rb_idx      <= '0;
         rb_data     <= '0;
         rb_valid    <= 1'b0;
         rb_last     <= 1'b0;
         in_ready    <= 1'b0;
         sc_shift_en <= 1'b0;
         sc_head     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         shift_reg   <= shift_n;
         bits_sent   <= bits_n;
         word_bits   <= wbits_n;
         rb_reg      <= rb_reg_n;
         rb_idx      <= rb_idx_n;
         rb_data     <= rb_data_n;
         rb_valid    <= rb_valid_n;
         rb_last     <= rb_last_n;
         in_ready    <= (state_n == LOAD);
         sc_shift_en <= (state_n == SHIFT);
         sc_head     <= (state_n == SHIFT) & shift_n[0];
         busy        <= (state_n != IDLE);
         done        <= (state_n == DONE);
      end
   end
endmodule

// File: doc/sc_chain_loader.md
Name: sc_chain_loader

Overview:
- Writer end of the configuration scan chain. Serialises configuration words from a host stream onto the head of a chain of scan-chain flip-flops.
- Drives the shift enable that gates the chain clock.
- Captures the bits falling out of the chain tail and returns them as readback words.
- Sits between the bitstream source (host/JTAG bridge) and the FPGA fabric configuration chain.

Parameters:
- DATA_WIDTH, 8, width of host input words and readback words (>=2).
- CHAIN_LEN, 64, total number of flip-flops in the chain, i.e. bits shifted per load (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), local width of the bit counter (derived, not overridable).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a full chain load; sampled only in IDLE.
- in_data  input  DATA_WIDTH  configuration word; bit 0 is shifted first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word this cycle.
- sc_head  output  1  serial data to the D input of the first chain flip-flop.
- sc_shift_en  output  1  chain clock-gate enable; the chain advances one bit on each clk edge where this is high.
- sc_tail  input  1  Q of the last chain flip-flop.
- rb_data  output  DATA_WIDTH  readback word; bit 0 is the first bit captured.
- rb_valid  output  1  one-cycle pulse, rb_data valid.
- rb_last  output  1  qualifies rb_valid for the final readback word of a load.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a load completes.

Behaviour:
- Reset (clk edge with reset=1):
  - Go to IDLE; clear shift register, bit counter, word-bit counter and readback register.
  - All outputs are registered and read 0 after reset, including in_ready, sc_shift_en and sc_head.
  - Reset overrides every other input, including mid-load. A partial load is abandoned and no done or rb pulse is produced.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - busy=0, in_ready=0.
  - start=1 -> LOAD next cycle; bit counter cleared.
  - in_valid is ignored in IDLE.
- LOAD:
  - in_ready=1, sc_shift_en=0.
  - When in_valid=1, latch in_data into the shift register, set word-bit counter = min(DATA_WIDTH, CHAIN_LEN - bits_sent), and go to SHIFT.
  - in_valid=0 -> stay in LOAD indefinitely.
- SHIFT:
  - In each cycle: sc_shift_en=1, sc_head = shift_reg[0], sc_tail sampled into the readback register at position rb_idx.
  - On the following edge: shift the register right, bits_sent+1, word bits-1.
  - When word bits reach 0: bits_sent==CHAIN_LEN -> DONE; otherwise -> LOAD.
  - in_ready=0 throughout SHIFT. Cost is DATA_WIDTH+1 cycles per full word, with no overlap.
- Partial last word: only CHAIN_LEN mod DATA_WIDTH low bits are shifted; the upper bits of that word are discarded. Exactly CHAIN_LEN shift_en cycles occur per load.
- Readback:
  - sc_tail sampled in a shift_en cycle is the chain's old tail bit, i.e. the previous configuration's content, oldest bit first.
  - When DATA_WIDTH bits have been collected, or on the final shift of a load: rb_valid=1 for one cycle, the cycle after that shift.
  - Unfilled high bits are zero; rb_idx is cleared.
  - rb_last=1 with the final word only.
- DONE:
  - done=1 for exactly one cycle, concurrent with the final rb_valid/rb_last pulse.
  - busy=1 in DONE; return to IDLE next cycle.
- start while busy is ignored; no queuing.
- sc_head and sc_shift_en change only on clk edges and are glitch-free for the external clock gate.

Test Plan:
- Full load, DATA_WIDTH=8, CHAIN_LEN=20:
  - Stimulus: start, then words 0xA5, 0x3C, 0x0F with in_valid held high.
  - Required: 3 handshakes; sc_head on shift_en cycles = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1; exactly 20 shift_en cycles; done one pulse; busy falls the cycle after done.
- Readback:
  - Stimulus: chain model (20-bit shift register on sc_shift_en) preloaded all-ones, then the same load.
  - Required: rb_data = 0xFF, 0xFF, 0x0F; rb_last only on the third word.
  - A second identical load returns 0xA5, 0x3C, 0x0F.
- Backpressure:
  - Stimulus: in_valid low for 5 cycles between words.
  - Required: loader holds in LOAD with in_ready=1, sc_shift_en=0; sc_head sequence and total shift count unchanged.
- Ignored inputs:
  - Stimulus: start pulsed during SHIFT; in_valid=1 while IDLE.
  - Required: no restart; no word accepted; in_ready stays 0 in IDLE.
- Reset mid-operation:
  - Stimulus: assert reset after the 11th shift.
  - Required: next cycle all outputs 0, state IDLE, no done/rb_valid.
  - A fresh start then completes a full 20-bit load correctly.
- CHAIN_LEN=1, DATA_WIDTH=8:
  - Stimulus: one word 0xFE.
  - Required: single shift_en cycle with sc_head=0; rb_valid with rb_last; rb_data bits 7:1 = 0.
